// File: rtl/mem_arbiter.sv
// Shares the single main-memory burst port between the icache refill path and the dcache refill/writeback path.
// Define ROUND_ROBIN_EN to alternate grants on simultaneous requests; otherwise the dcache always wins.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req_valid_i,
    output logic              ic_req_ready_o,
    input  logic [ADDR_W-1:0] ic_req_addr_i,
    output logic              ic_resp_valid_o,
    output logic [DATA_W-1:0] ic_resp_data_o,
    input  logic              dc_req_valid_i,
    output logic              dc_req_ready_o,
    input  logic              dc_req_rw_i,
    input  logic [ADDR_W-1:0] dc_req_addr_i,
    input  logic              dc_wdata_valid_i,
    output logic              dc_wdata_ready_o,
    input  logic [DATA_W-1:0] dc_wdata_i,
    output logic              dc_resp_valid_o,
    output logic [DATA_W-1:0] dc_resp_data_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_rw_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic              mem_wdata_valid_o,
    input  logic              mem_wdata_ready_i,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_resp_data_i,
    output logic              protocol_err_o
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WRITE,
        READ
    } state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [BEAT_W-1:0]   beat_d;
    logic                grantDc_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                rw_q;
    logic                memReqValid_q;
    logic                protoErr_q;
    logic                dcWins;
    logic                icWins;
    logic                anyReq;
    logic                lastBeat;

`ifdef ROUND_ROBIN_EN
    logic                lastGrantDc_q;

    // On a tie the requester that did not win last time gets the port.
    assign dcWins = dc_req_valid_i && (!ic_req_valid_i || !lastGrantDc_q);
`else
    assign dcWins = dc_req_valid_i;
`endif

    assign icWins   = ic_req_valid_i && !dcWins;
    assign anyReq   = ic_req_valid_i || dc_req_valid_i;
    assign beat_d   = beat_q + 1'b1;
    assign lastBeat = (beat_q == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            grantDc_q     <= 1'b1;
            addr_q        <= '0;
            rw_q          <= 1'b0;
            memReqValid_q <= 1'b0;
            protoErr_q    <= 1'b0;
`ifdef ROUND_ROBIN_EN
            lastGrantDc_q <= 1'b1;
`endif
        end else begin
            // Memory has no backpressure on responses, so a stray beat can only be flagged.
            if (mem_resp_valid_i && (state_q != READ)) begin
                protoErr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        grantDc_q     <= dcWins;
                        addr_q        <= dcWins ? dc_req_addr_i : ic_req_addr_i;
                        rw_q          <= dcWins && dc_req_rw_i;
                        memReqValid_q <= 1'b1;
                        state_q       <= ISSUE;
`ifdef ROUND_ROBIN_EN
                        lastGrantDc_q <= dcWins;
`endif
                    end
                end
                ISSUE: begin
                    if (mem_req_ready_i) begin
                        memReqValid_q <= 1'b0;
                        state_q       <= rw_q ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (dc_wdata_valid_i && mem_wdata_ready_i) begin
                        beat_q <= beat_d;
                        if (lastBeat) begin
                            state_q <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (mem_resp_valid_i) begin
                        beat_q <= beat_d;
                        if (lastBeat) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is gated by reset so nothing looks accepted while the block is held in reset.
    assign ic_req_ready_o    = rst_n && (state_q == IDLE) && icWins;
    assign dc_req_ready_o    = rst_n && (state_q == IDLE) && dcWins;

    assign mem_req_valid_o   = memReqValid_q;
    assign mem_req_rw_o      = rw_q;
    assign mem_req_addr_o    = addr_q;
    assign protocol_err_o    = protoErr_q;

    assign mem_wdata_valid_o = (state_q == WRITE) && dc_wdata_valid_i;
    assign dc_wdata_ready_o  = (state_q == WRITE) && mem_wdata_ready_i;
    assign mem_wdata_o       = dc_wdata_i;

    assign ic_resp_valid_o   = (state_q == READ) && !grantDc_q && mem_resp_valid_i;
    assign dc_resp_valid_o   = (state_q == READ) && grantDc_q && mem_resp_valid_i;
    assign ic_resp_data_o    = ic_resp_valid_o ? mem_resp_data_i : '0;
    assign dc_resp_data_o    = dc_resp_valid_o ? mem_resp_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter; the bench plays both caches and main memory.
// The arbitration model follows ROUND_ROBIN_EN the same way the design build does.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic_req_valid_i, ic_req_ready_o, ic_resp_valid_o;
    logic [AW-1:0] ic_req_addr_i;
    logic [DW-1:0] ic_resp_data_o;
    logic          dc_req_valid_i, dc_req_ready_o, dc_req_rw_i;
    logic [AW-1:0] dc_req_addr_i;
    logic          dc_wdata_valid_i, dc_wdata_ready_o, dc_resp_valid_o;
    logic [DW-1:0] dc_wdata_i, dc_resp_data_o;
    logic          mem_req_valid_o, mem_req_ready_i, mem_req_rw_o;
    logic [AW-1:0] mem_req_addr_o;
    logic          mem_wdata_valid_o, mem_wdata_ready_i;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_resp_valid_i;
    logic [DW-1:0] mem_resp_data_i;
    logic          protocol_err_o;

    int checks   = 0;
    int failures = 0;
    bit lastWasDc = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o),
        .ic_req_addr_i(ic_req_addr_i), .ic_resp_valid_o(ic_resp_valid_o),
        .ic_resp_data_o(ic_resp_data_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o),
        .dc_req_rw_i(dc_req_rw_i), .dc_req_addr_i(dc_req_addr_i),
        .dc_wdata_valid_i(dc_wdata_valid_i), .dc_wdata_ready_o(dc_wdata_ready_o),
        .dc_wdata_i(dc_wdata_i), .dc_resp_valid_o(dc_resp_valid_o),
        .dc_resp_data_o(dc_resp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_rw_o(mem_req_rw_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_wdata_valid_o(mem_wdata_valid_o), .mem_wdata_ready_i(mem_wdata_ready_i),
        .mem_wdata_o(mem_wdata_o), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_data_i(mem_resp_data_i), .protocol_err_o(protocol_err_o)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] randBeat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic writePhase(input bit directed);
        logic [DW-1:0] beats[BL];
        int beat  = 0;
        int guard = 0;
        bit toggle = 1'b0;
        bit dv, mr;
        for (int i = 0; i < BL; i++) beats[i] = directed ? DW'(i + 1) : randBeat();
        while (beat < BL && guard < 200) begin
            if (directed) begin
                dv = 1'b1;
                mr = toggle;
                toggle = !toggle;
            end else begin
                dv = ($urandom_range(0, 3) != 0);
                mr = 1'($urandom_range(0, 1));
            end
            dc_wdata_valid_i  = dv;
            mem_wdata_ready_i = mr;
            dc_wdata_i        = beats[beat];
            #1;
            checkOutput("wValid", mem_wdata_valid_o, dv);
            checkOutput("wReady", dc_wdata_ready_o, mr);
            if (dv) checkOutput("wData", mem_wdata_o, beats[beat]);
            if (dv && mr) beat++;
            guard++;
            stepCycle();
        end
        checkOutput("wBeats", beat, BL);
        dc_wdata_valid_i  = 1'b1;
        mem_wdata_ready_i = 1'b1;
        #1;
        checkOutput("wDoneValid", mem_wdata_valid_o, 1'b0);
        checkOutput("wDoneReady", dc_wdata_ready_o, 1'b0);
        dc_wdata_valid_i  = 1'b0;
        mem_wdata_ready_i = 1'b0;
    endtask

    task automatic readPhase(input bit toDc, input bit directed, input int resetBeat);
        logic [DW-1:0] d;
        int gap;
        for (int b = 0; b < BL; b++) begin
            gap = directed ? 0 : $urandom_range(0, 2);
            repeat (gap) begin
                mem_resp_valid_i = 1'b0;
                mem_resp_data_i  = randBeat();
                #1;
                checkOutput("rGapIc", ic_resp_valid_o, 1'b0);
                checkOutput("rGapDc", dc_resp_valid_o, 1'b0);
                stepCycle();
            end
            d = directed ? DW'(32'hA + b) : randBeat();
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = d;
            #1;
            if (b == resetBeat) begin
                rst_n          = 1'b0;
                ic_req_valid_i = 1'b1;
                #1;
                checkOutput("rstIcValid", ic_resp_valid_o, 1'b0);
                checkOutput("rstDcValid", dc_resp_valid_o, 1'b0);
                checkOutput("rstIcData", ic_resp_data_o, '0);
                checkOutput("rstMemReq", mem_req_valid_o, 1'b0);
                checkOutput("rstIcReady", ic_req_ready_o, 1'b0);
                ic_req_valid_i   = 1'b0;
                mem_resp_valid_i = 1'b0;
                stepCycle();
                stepCycle();
                rst_n     = 1'b1;
                lastWasDc = 1'b1;
                return;
            end
            checkOutput("rIcValid", ic_resp_valid_o, !toDc);
            checkOutput("rDcValid", dc_resp_valid_o, toDc);
            checkOutput("rIcData", ic_resp_data_o, toDc ? '0 : d);
            checkOutput("rDcData", dc_resp_data_o, toDc ? d : '0);
            stepCycle();
        end
        mem_resp_valid_i = 1'b0;
        #1;
        checkOutput("rEndIc", ic_resp_valid_o, 1'b0);
        checkOutput("rEndDc", dc_resp_valid_o, 1'b0);
    endtask

    // One complete burst: offer requests, expect the modelled winner, then run its data phase.
    task automatic applyStimulus(input bit icV, input bit dcV, input bit dcRw,
                                 input logic [AW-1:0] icA, input logic [AW-1:0] dcA,
                                 input int stall, input bit directed, input int resetBeat);
        bit expDc, expRw;
        logic [AW-1:0] expA;
`ifdef ROUND_ROBIN_EN
        expDc = dcV && (!icV || !lastWasDc);
`else
        expDc = dcV;
`endif
        expRw = expDc && dcRw;
        expA  = expDc ? dcA : icA;
        ic_req_valid_i = icV;
        ic_req_addr_i  = icA;
        dc_req_valid_i = dcV;
        dc_req_rw_i    = dcRw;
        dc_req_addr_i  = dcA;
        #1;
        checkOutput("aIcReady", ic_req_ready_o, icV && !expDc);
        checkOutput("aDcReady", dc_req_ready_o, expDc);
        checkOutput("aMemValid", mem_req_valid_o, 1'b0);
        stepCycle();
        lastWasDc = expDc;
        ic_req_valid_i  = 1'b1;
        dc_req_valid_i  = 1'b1;
        mem_req_ready_i = 1'b0;
        if (stall < 0) stall = $urandom_range(0, 3);
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) mem_req_ready_i = 1'b1;
            #1;
            checkOutput("iValid", mem_req_valid_o, 1'b1);
            checkOutput("iAddr", mem_req_addr_o, expA);
            checkOutput("iRw", mem_req_rw_o, expRw);
            checkOutput("iIcReady", ic_req_ready_o, 1'b0);
            checkOutput("iDcReady", dc_req_ready_o, 1'b0);
            stepCycle();
        end
        mem_req_ready_i = 1'b0;
        ic_req_valid_i  = 1'b0;
        dc_req_valid_i  = 1'b0;
        ic_req_addr_i   = $urandom();
        dc_req_addr_i   = $urandom();
        #1;
        checkOutput("iDone", mem_req_valid_o, 1'b0);
        checkOutput("iHold", mem_req_addr_o, expA);
        if (expRw) writePhase(directed);
        else readPhase(expDc, directed, resetBeat);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [AW-1:0] ra, rb;
        bit icV, dcV;
        rst_n = 1'b0;
        ic_req_valid_i = 1'b0; ic_req_addr_i = '0;
        dc_req_valid_i = 1'b0; dc_req_rw_i = 1'b0; dc_req_addr_i = '0;
        dc_wdata_valid_i = 1'b0; dc_wdata_i = '0;
        mem_req_ready_i = 1'b0; mem_wdata_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        ic_req_valid_i = 1'b1;
        dc_req_valid_i = 1'b1;
        #1;
        checkOutput("resetIcReady", ic_req_ready_o, 1'b0);
        checkOutput("resetDcReady", dc_req_ready_o, 1'b0);
        ic_req_valid_i = 1'b0;
        dc_req_valid_i = 1'b0;
        #1;
        checkOutput("resetMemValid", mem_req_valid_o, 1'b0);
        checkOutput("resetAddr", mem_req_addr_o, '0);
        checkOutput("resetRw", mem_req_rw_o, 1'b0);
        checkOutput("resetWValid", mem_wdata_valid_o, 1'b0);
        checkOutput("resetPerr", protocol_err_o, 1'b0);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        checkOutput("idleStay0", mem_req_valid_o, 1'b0);
        stepCycle();
        checkOutput("idleStay1", mem_req_valid_o, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1, 1'b1, -1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 0, 1'b1, -1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h400, 0, 1'b0, -1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h500, 32'h600, 0, 1'b0, -1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h700, 10, 1'b0, -1);

        for (int t = 0; t < 24; t++) begin
            do begin
                icV = 1'($urandom_range(0, 1));
                dcV = 1'($urandom_range(0, 1));
            end while (!icV && !dcV);
            ra = $urandom() & ~32'h3F;
            rb = $urandom() & ~32'h3F;
            applyStimulus(icV, dcV, 1'($urandom_range(0, 1)), ra, rb, -1, 1'b0, -1);
        end
        checkOutput("perrClean", protocol_err_o, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 0, 1'b1, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 0, 1'b1, -1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hA00, 32'hB00, 0, 1'b0, -1);

        stepCycle();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = randBeat();
        #1;
        checkOutput("pIcValid", ic_resp_valid_o, 1'b0);
        checkOutput("pDcValid", dc_resp_valid_o, 1'b0);
        stepCycle();
        mem_resp_valid_i = 1'b0;
        #1;
        checkOutput("pErrSet", protocol_err_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("pErrSticky", protocol_err_o, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'hC00, 32'h0, 0, 1'b0, -1);
        checkOutput("pErrAfter", protocol_err_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
